// File: rtl/aes_shiftrow_seq.sv
`default_nettype none
// ============================================================================
// Module   : aes_shiftrow_seq
// Brief    : Streaming AES ShiftRows / InvShiftRows over NBEATS beats of
//            BEAT_W bits. Define AES_SR_PINGPONG_EN to let the next block
//            load while the current block drains.
// Revision : 1.0 - initial release
// ============================================================================
module aes_shiftrow_seq #(
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_data,
  input  logic              in_inv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_last
);

  localparam int NBEATS = 128 / BEAT_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(NBEATS - 1);

  generate
    if (BEAT_W != 32 && BEAT_W != 64 && BEAT_W != 128) begin : g_bad_beat_w
      $error("aes_shiftrow_seq: BEAT_W must be 32, 64 or 128");
    end
  endgenerate

  // Byte j = row j%4, column j/4; each row r rotates by r columns.
  function automatic logic [127:0] f_shift_rows(input logic [127:0] st, input logic inv);
    logic [127:0] res;
    int r, c, src;
    res = '0;
    for (int j = 0; j < 16; j++) begin
      r   = j % 4;
      c   = j / 4;
      src = inv ? 4 * ((c - r + 4) % 4) + r : 4 * ((c + r) % 4) + r;
      res[8*j +: 8] = st[8*src +: 8];
    end
    return res;
  endfunction

  logic [127:0]     r_ibuf;
  logic [127:0]     r_obuf;
  logic [CNT_W-1:0] r_in_cnt;
  logic [CNT_W-1:0] r_out_cnt;
  logic             r_inv;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [127:0]     w_blk;
  logic             w_inv;
  logic             w_in_fire;
  logic             w_in_last;
  logic             w_out_fire;
  logic             w_out_end;

  // The block as it stands once the current beat lands in its slot.
  always_comb begin
    w_blk = r_ibuf;
    w_blk[r_in_cnt*BEAT_W +: BEAT_W] = in_data;
  end

  assign w_inv      = (r_in_cnt == '0) ? in_inv : r_inv;
  assign w_in_fire  = in_valid && r_in_ready;
  assign w_in_last  = (r_in_cnt == C_LAST_CNT);
  assign w_out_fire = r_out_valid && out_ready;
  assign w_out_end  = w_out_fire && (r_out_cnt == C_LAST_CNT);

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_obuf[r_out_cnt*BEAT_W +: BEAT_W];
  assign out_last  = r_out_valid && (r_out_cnt == C_LAST_CNT);

`ifdef AES_SR_PINGPONG_EN
  logic r_ifull;
  logic w_obuf_free;
  logic w_xfer_live;
  logic w_xfer_stored;
  logic w_ifull_nxt;

  assign w_obuf_free   = !r_out_valid || w_out_end;
  assign w_xfer_live   = w_in_fire && w_in_last && w_obuf_free;
  assign w_xfer_stored = r_ifull && w_obuf_free;
  assign w_ifull_nxt   = r_ifull ? !w_obuf_free : (w_in_fire && w_in_last && !w_obuf_free);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ibuf      <= '0;
      r_obuf      <= '0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_inv       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_ifull     <= 1'b0;
    end else begin
      r_ifull    <= w_ifull_nxt;
      r_in_ready <= !w_ifull_nxt;
      if (w_in_fire) begin
        r_ibuf[r_in_cnt*BEAT_W +: BEAT_W] <= in_data;
        if (r_in_cnt == '0) r_inv <= in_inv;
        r_in_cnt <= w_in_last ? '0 : r_in_cnt + 1'b1;
      end
      if (w_out_fire) begin
        r_out_cnt <= w_out_end ? '0 : r_out_cnt + 1'b1;
        if (w_out_end) r_out_valid <= 1'b0;
      end
      if (w_xfer_live) begin
        r_obuf      <= f_shift_rows(w_blk, w_inv);
        r_out_valid <= 1'b1;
      end else if (w_xfer_stored) begin
        r_obuf      <= f_shift_rows(r_ibuf, r_inv);
        r_out_valid <= 1'b1;
      end
    end
  end
`else
  typedef enum logic [0:0] {
    ST_LOAD  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_LOAD;
      r_ibuf      <= '0;
      r_obuf      <= '0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_inv       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_in_ready <= 1'b1;
          if (w_in_fire) begin
            r_ibuf[r_in_cnt*BEAT_W +: BEAT_W] <= in_data;
            if (r_in_cnt == '0) r_inv <= in_inv;
            if (w_in_last) begin
              r_in_cnt    <= '0;
              r_obuf      <= f_shift_rows(w_blk, w_inv);
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
              r_state     <= ST_DRAIN;
            end else begin
              r_in_cnt <= r_in_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (w_out_fire) begin
            if (w_out_end) begin
              r_out_cnt   <= '0;
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
              r_state     <= ST_LOAD;
            end else begin
              r_out_cnt <= r_out_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end
`endif

endmodule
`default_nettype wire
